sram_fifo_mc: RTL and testbench
===============================

Name: sram_fifo_mc

Overview:
Single-clock, multi-channel FIFO that stores NUM_CH independent queues in one external dual-port SRAM through the sram_if initiator modport. Each channel owns a fixed 2^CH_DEPTH_W-entry partition; the address is {zero pad, channel, pointer}. Per channel the block provides full, empty, level, programmable almost-full/almost-empty, flush and sticky overflow/underflow flags. Read data returns through a latency-matched valid/channel-tag pipeline.

Parameters:
NUM_CH, 4, number of channels (power of 2)
CH_SEL_W, 2, channel select width, = log2(NUM_CH)
CH_DEPTH_W, 8, log2 of entries per channel
FIFO_W, 64, data width, = SRAM_DATA_W
SRAM_DATA_W, 64, SRAM data width
SRAM_ADDR_W, 14, SRAM address width, >= CH_SEL_W+CH_DEPTH_W
SRAM_RD_LAT, 1, cycles from rd_l low to SRAM_IF.rdata valid (1..4)
AFULL_TH, 2^CH_DEPTH_W-2, almost-full threshold
AEMPTY_TH, 2, almost-empty threshold

Ports:
CLK  in  1  clock
RESET  in  1  synchronous reset, active-high
fifo_wr  in  1  write request
fifo_wr_ch  in  CH_SEL_W  write channel
fifo_wdata  in  FIFO_W  write data
fifo_rd  in  1  read request
fifo_rd_ch  in  CH_SEL_W  read channel
fifo_flush  in  NUM_CH  per-channel flush
err_clr  in  1  clears sticky errors
fifo_rdata  out  FIFO_W  read data (= SRAM_IF.rdata)
fifo_rvalid  out  1  fifo_rdata valid
fifo_rch  out  CH_SEL_W  channel of fifo_rdata
fifo_empty  out  NUM_CH  per-channel empty
fifo_full  out  NUM_CH  per-channel full
fifo_aempty  out  NUM_CH  level <= AEMPTY_TH
fifo_afull  out  NUM_CH  level >= AFULL_TH
fifo_level  out  NUM_CH*(CH_DEPTH_W+1)  packed levels, ch0 in LSBs
ovf_err  out  NUM_CH  sticky write-when-full
udf_err  out  NUM_CH  sticky read-when-empty
SRAM_IF  sram_if.initiator  -  rd_l, wr_l, rd_address, wr_address, wdata, rdata

Behaviour:
- Clock CLK; reset RESET is synchronous, active-high.
- Reset: all pointers/levels 0, fifo_empty all 1, fifo_aempty all 1, fifo_full/fifo_afull 0, fifo_rvalid 0, fifo_rch 0, ovf_err/udf_err 0. Reset mid-operation discards in-flight reads; no rvalid after reset.
- Write accepted = fifo_wr & ~fifo_full[wr_ch] & ~fifo_flush[wr_ch]. It drives wr_l=0, wr_address={0, wr_ch, wr_ptr[wr_ch]}, wdata=fifo_wdata in the same cycle. wr_l=1 otherwise.
- Read accepted = fifo_rd & ~fifo_empty[rd_ch] & ~fifo_flush[rd_ch]. It drives rd_l=0, rd_address={0, rd_ch, rd_ptr[rd_ch]}. rd_l=1 otherwise; SRAM is never read for rejected requests.
- Pointers are CH_DEPTH_W bits per channel and wrap 2^CH_DEPTH_W-1 -> 0. Level is CH_DEPTH_W+1 bits, range 0..2^CH_DEPTH_W.
- Level, flags, pointers are registered and update on the edge ending the accepting cycle.
- Flags next cycle: empty = (level==0); full = (level==2^CH_DEPTH_W); aempty/afull compare against the thresholds.
- Simultaneous accepted write and read, same channel: both pointers advance, level unchanged. A read on an empty channel is rejected even if a write to it occurs that cycle; write-to-read turnaround is 1 cycle.
- Simultaneous accepted write and read, different channels: independent.
- Read return: fifo_rvalid=1 and fifo_rch=accepted rd_ch exactly SRAM_RD_LAT cycles after acceptance. Pipeline is a SRAM_RD_LAT-deep shift register and sustains one read per cycle. fifo_rdata is meaningful only while fifo_rvalid=1.
- Flush[c]: on the next edge, rd_ptr/wr_ptr/level of channel c become 0 and empty[c]=1. Flush overrides same-cycle wr/rd on c; these are not errors. Reads already in flight still return with rvalid.
- Errors: fifo_wr on full (not flushed) sets ovf_err[wr_ch]; fifo_rd on empty (not flushed) sets udf_err[rd_ch]. err_clr clears all; a same-cycle set wins over err_clr.
- Reject = no state change except the error flag.

Test Plan:
- NUM_CH=4, CH_DEPTH_W=3: RESET 2 cycles -> empty=4'b1111, full=0, levels 0, rvalid 0, rd_l=wr_l=1.
- Write 8 words 0..7 to ch2 -> full[2]=1 the cycle after the 8th; 9th write: wr_l=1, ovf_err[2]=1, level2=8. Read 8 -> data 0..7 in order with rch=2, then empty[2]=1.
- SRAM_RD_LAT=2: back-to-back reads ch0, ch1, ch0 -> rvalid for 3 consecutive cycles starting 2 cycles after the first read, rch=0,1,0.
- Ch1 at level 4, write+read ch1 same cycle for 10 cycles -> level stays 4; pointers wrap; data in order.
- Ch3 at level 5, flush[3] with same-cycle write to ch3 -> level3=0, empty[3]=1, no ovf_err, wr_l=1.
- Read on empty ch0 -> udf_err[0]=1, rd_l=1. err_clr -> 0. Read accepted then RESET next cycle -> no rvalid.

Source files
------------

// File: rtl/sram_fifo_mc_if.sv
// rtl/sram_fifo_mc_if.sv - dual-port SRAM interface used by the multi-channel FIFO
interface sram_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
);
  logic              rd_l;
  logic              wr_l;
  logic [ADDR_W-1:0] rd_address;
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport initiator (output rd_l, wr_l, rd_address, wr_address, wdata, input rdata);
  modport target (input rd_l, wr_l, rd_address, wr_address, wdata, output rdata);
endinterface

// File: rtl/sram_fifo_mc.sv
// rtl/sram_fifo_mc.sv - multi-channel FIFO with per-channel partitions in one dual-port SRAM
module sram_fifo_mc #(
  parameter int NUM_CH      = 4,
  parameter int CH_SEL_W    = 2,
  parameter int CH_DEPTH_W  = 8,
  parameter int FIFO_W      = 64,
  parameter int SRAM_DATA_W = 64,
  parameter int SRAM_ADDR_W = 14,
  parameter int SRAM_RD_LAT = 1,
  parameter int AFULL_TH    = (1 << CH_DEPTH_W) - 2,
  parameter int AEMPTY_TH   = 2
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             fifo_wr,
  input  logic [CH_SEL_W-1:0]              fifo_wr_ch,
  input  logic [FIFO_W-1:0]                fifo_wdata,
  input  logic                             fifo_rd,
  input  logic [CH_SEL_W-1:0]              fifo_rd_ch,
  input  logic [NUM_CH-1:0]                fifo_flush,
  input  logic                             err_clr,
  output logic [FIFO_W-1:0]                fifo_rdata,
  output logic                             fifo_rvalid,
  output logic [CH_SEL_W-1:0]              fifo_rch,
  output logic [NUM_CH-1:0]                fifo_empty,
  output logic [NUM_CH-1:0]                fifo_full,
  output logic [NUM_CH-1:0]                fifo_aempty,
  output logic [NUM_CH-1:0]                fifo_afull,
  output logic [NUM_CH*(CH_DEPTH_W+1)-1:0] fifo_level,
  output logic [NUM_CH-1:0]                ovf_err,
  output logic [NUM_CH-1:0]                udf_err,
  sram_if.initiator                        SRAM_IF
);
  localparam int LVL_W = CH_DEPTH_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL  = LVL_W'(1 << CH_DEPTH_W);
  localparam logic [LVL_W-1:0] AFULL_LVL  = LVL_W'(AFULL_TH);
  localparam logic [LVL_W-1:0] AEMPTY_LVL = LVL_W'(AEMPTY_TH);

  logic [CH_DEPTH_W-1:0]  wr_ptr    [NUM_CH];
  logic [CH_DEPTH_W-1:0]  rd_ptr    [NUM_CH];
  logic [LVL_W-1:0]       level     [NUM_CH];
  logic [LVL_W-1:0]       level_nxt [NUM_CH];
  logic [NUM_CH-1:0]      wr_hit;
  logic [NUM_CH-1:0]      rd_hit;
  logic [NUM_CH-1:0]      ovf_set;
  logic [NUM_CH-1:0]      udf_set;
  logic                   wr_acc;
  logic                   rd_acc;
  logic [SRAM_ADDR_W-1:0] wr_addr;
  logic [SRAM_ADDR_W-1:0] rd_addr;
  logic [SRAM_RD_LAT-1:0] vld_sr;
  logic [CH_SEL_W-1:0]    ch_sr     [SRAM_RD_LAT];

  // Flags are registered, so acceptance only looks at state from the previous edge.
  assign wr_acc = fifo_wr & ~fifo_full[fifo_wr_ch]  & ~fifo_flush[fifo_wr_ch];
  assign rd_acc = fifo_rd & ~fifo_empty[fifo_rd_ch] & ~fifo_flush[fifo_rd_ch];

  always_comb begin
    wr_addr = '0;
    rd_addr = '0;
    wr_addr[CH_SEL_W+CH_DEPTH_W-1:0] = {fifo_wr_ch, wr_ptr[fifo_wr_ch]};
    rd_addr[CH_SEL_W+CH_DEPTH_W-1:0] = {fifo_rd_ch, rd_ptr[fifo_rd_ch]};
  end

  assign SRAM_IF.wr_l       = ~wr_acc;
  assign SRAM_IF.rd_l       = ~rd_acc;
  assign SRAM_IF.wr_address = wr_addr;
  assign SRAM_IF.rd_address = rd_addr;
  assign SRAM_IF.wdata      = SRAM_DATA_W'(fifo_wdata);
  assign fifo_rdata         = FIFO_W'(SRAM_IF.rdata);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c]  = wr_acc && (int'(fifo_wr_ch) == c);
      rd_hit[c]  = rd_acc && (int'(fifo_rd_ch) == c);
      ovf_set[c] = fifo_wr && (int'(fifo_wr_ch) == c) && fifo_full[c]  && !fifo_flush[c];
      udf_set[c] = fifo_rd && (int'(fifo_rd_ch) == c) && fifo_empty[c] && !fifo_flush[c];
      if (fifo_flush[c])
        level_nxt[c] = '0;
      else if (wr_hit[c] && !rd_hit[c])
        level_nxt[c] = level[c] + LVL_W'(1);
      else if (rd_hit[c] && !wr_hit[c])
        level_nxt[c] = level[c] - LVL_W'(1);
      else
        level_nxt[c] = level[c];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        level[c]  <= '0;
      end
      fifo_empty  <= '1;
      fifo_aempty <= '1;
      fifo_full   <= '0;
      fifo_afull  <= '0;
      ovf_err     <= '0;
      udf_err     <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (fifo_flush[c]) begin
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
        end else begin
          if (wr_hit[c]) wr_ptr[c] <= wr_ptr[c] + CH_DEPTH_W'(1);
          if (rd_hit[c]) rd_ptr[c] <= rd_ptr[c] + CH_DEPTH_W'(1);
        end
        level[c]       <= level_nxt[c];
        fifo_empty[c]  <= (level_nxt[c] == '0);
        fifo_full[c]   <= (level_nxt[c] == DEPTH_LVL);
        fifo_aempty[c] <= (level_nxt[c] <= AEMPTY_LVL);
        fifo_afull[c]  <= (level_nxt[c] >= AFULL_LVL);
      end
      // A new error in the same cycle as err_clr survives the clear.
      ovf_err <= (err_clr ? '0 : ovf_err) | ovf_set;
      udf_err <= (err_clr ? '0 : udf_err) | udf_set;
    end
  end

  // Valid/channel tag travels alongside the SRAM read latency.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_sr <= '0;
      for (int i = 0; i < SRAM_RD_LAT; i++) ch_sr[i] <= '0;
    end else begin
      vld_sr[0] <= rd_acc;
      ch_sr[0]  <= fifo_rd_ch;
      for (int i = 1; i < SRAM_RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        ch_sr[i]  <= ch_sr[i-1];
      end
    end
  end

  assign fifo_rvalid = vld_sr[SRAM_RD_LAT-1];
  assign fifo_rch    = ch_sr[SRAM_RD_LAT-1];

  always_comb begin
    fifo_level = '0;
    for (int c = 0; c < NUM_CH; c++) fifo_level[c*LVL_W +: LVL_W] = level[c];
  end
endmodule

// File: tb/tb_sram_fifo_mc.sv
// tb/tb_sram_fifo_mc.sv - directed bench for sram_fifo_mc with a queue-based reference model
module tb_sram_fifo_mc;
  localparam int NCH = 4, CSW = 2, DW = 3, DEPTH = 8, W = 64, AW = 14, LAT = 2, AF = 6, AE = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          fifo_wr;
  logic [CSW-1:0] fifo_wr_ch;
  logic [W-1:0]  fifo_wdata;
  logic          fifo_rd;
  logic [CSW-1:0] fifo_rd_ch;
  logic [NCH-1:0] fifo_flush;
  logic          err_clr;
  logic [W-1:0]  fifo_rdata;
  logic          fifo_rvalid;
  logic [CSW-1:0] fifo_rch;
  logic [NCH-1:0] fifo_empty, fifo_full, fifo_aempty, fifo_afull, ovf_err, udf_err;
  logic [NCH*(DW+1)-1:0] fifo_level;

  sram_if #(.ADDR_W(AW), .DATA_W(W)) sif ();

  sram_fifo_mc #(
    .NUM_CH(NCH), .CH_SEL_W(CSW), .CH_DEPTH_W(DW), .FIFO_W(W), .SRAM_DATA_W(W),
    .SRAM_ADDR_W(AW), .SRAM_RD_LAT(LAT), .AFULL_TH(AF), .AEMPTY_TH(AE)
  ) dut (
    .CLK(CLK), .RESET(RESET), .fifo_wr(fifo_wr), .fifo_wr_ch(fifo_wr_ch), .fifo_wdata(fifo_wdata),
    .fifo_rd(fifo_rd), .fifo_rd_ch(fifo_rd_ch), .fifo_flush(fifo_flush), .err_clr(err_clr),
    .fifo_rdata(fifo_rdata), .fifo_rvalid(fifo_rvalid), .fifo_rch(fifo_rch),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_aempty(fifo_aempty),
    .fifo_afull(fifo_afull), .fifo_level(fifo_level), .ovf_err(ovf_err), .udf_err(udf_err),
    .SRAM_IF(sif)
  );

  always #5 CLK = ~CLK;

  // SRAM: data valid LAT cycles after rd_l low
  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [W-1:0] rpipe [LAT];
  always @(posedge CLK) begin
    if (!sif.wr_l) mem[sif.wr_address] <= sif.wdata;
    rpipe[0] <= sif.rd_l ? 'x : mem[sif.rd_address];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign sif.rdata = rpipe[LAT-1];

  int vectors = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue of words per channel plus a schedule of read returns
  typedef struct { int due; logic [CSW-1:0] ch; logic [W-1:0] d; } ret_t;
  logic [W-1:0] q [NCH][$];
  int wcnt [NCH];
  int rcnt [NCH];
  logic [NCH-1:0] m_ovf, m_udf;
  ret_t pend [$];
  int cyc = 0;
  bit en = 0;

  function automatic bit m_wacc();
    return fifo_wr && (q[fifo_wr_ch].size() < DEPTH) && !fifo_flush[fifo_wr_ch];
  endfunction
  function automatic bit m_racc();
    return fifo_rd && (q[fifo_rd_ch].size() != 0) && !fifo_flush[fifo_rd_ch];
  endfunction

  always @(posedge CLK) begin : model
    bit wa, ra;
    ret_t r;
    logic [NCH-1:0] os, us;
    if (RESET) begin
      for (int c = 0; c < NCH; c++) begin q[c].delete(); wcnt[c] = 0; rcnt[c] = 0; end
      m_ovf = '0; m_udf = '0;
      pend.delete();
      en = 1;
    end else if (en) begin
      wa = m_wacc();
      ra = m_racc();
      os = '0; us = '0;
      if (fifo_wr && q[fifo_wr_ch].size() == DEPTH && !fifo_flush[fifo_wr_ch]) os[fifo_wr_ch] = 1'b1;
      if (fifo_rd && q[fifo_rd_ch].size() == 0 && !fifo_flush[fifo_rd_ch]) us[fifo_rd_ch] = 1'b1;
      m_ovf = (err_clr ? '0 : m_ovf) | os;
      m_udf = (err_clr ? '0 : m_udf) | us;
      if (ra) begin
        r.due = cyc + LAT; r.ch = fifo_rd_ch; r.d = q[fifo_rd_ch].pop_front();
        pend.push_back(r);
        rcnt[fifo_rd_ch]++;
      end
      if (wa) begin
        q[fifo_wr_ch].push_back(fifo_wdata);
        wcnt[fifo_wr_ch]++;
      end
      for (int c = 0; c < NCH; c++)
        if (fifo_flush[c]) begin q[c].delete(); wcnt[c] = 0; rcnt[c] = 0; end
    end
    cyc++;
  end

  always @(negedge CLK) begin : compare
    logic [NCH-1:0] ee, ef, ea, eaf;
    logic [NCH*(DW+1)-1:0] el;
    if (en) begin
      for (int c = 0; c < NCH; c++) begin
        ee[c]  = (q[c].size() == 0);
        ef[c]  = (q[c].size() == DEPTH);
        ea[c]  = (q[c].size() <= AE);
        eaf[c] = (q[c].size() >= AF);
        el[c*(DW+1) +: DW+1] = 4'(q[c].size());
      end
      chk("empty", fifo_empty, ee);
      chk("full", fifo_full, ef);
      chk("aempty", fifo_aempty, ea);
      chk("afull", fifo_afull, eaf);
      chk("level", fifo_level, el);
      chk("ovf_err", ovf_err, m_ovf);
      chk("udf_err", udf_err, m_udf);
      chk("wr_l", sif.wr_l, !m_wacc());
      chk("rd_l", sif.rd_l, !m_racc());
      if (m_wacc()) begin
        chk("wr_address", sif.wr_address, fifo_wr_ch * DEPTH + wcnt[fifo_wr_ch] % DEPTH);
        chk("wdata", sif.wdata, fifo_wdata);
      end
      if (m_racc()) chk("rd_address", sif.rd_address, fifo_rd_ch * DEPTH + rcnt[fifo_rd_ch] % DEPTH);
      if (pend.size() > 0 && pend[0].due == cyc) begin
        chk("rvalid", fifo_rvalid, 1'b1);
        chk("rch", fifo_rch, pend[0].ch);
        chk("rdata", fifo_rdata, pend[0].d);
        void'(pend.pop_front());
      end else begin
        chk("rvalid_idle", fifo_rvalid, 1'b0);
      end
    end
  end

  task automatic drive(input bit wr, input int wch, input logic [W-1:0] wd, input bit rd, input int rch,
                       input logic [NCH-1:0] fl = '0, input bit clr = 1'b0, input bit rst = 1'b0);
    @(posedge CLK); #1;
    fifo_wr = wr; fifo_wr_ch = CSW'(wch); fifo_wdata = wd;
    fifo_rd = rd; fifo_rd_ch = CSW'(rch);
    fifo_flush = fl; err_clr = clr; RESET = rst;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0);
  endtask

  initial begin
    logic [5:0] exp_v;
    logic [CSW-1:0] rseq [3];
    logic [CSW-1:0] rch_exp [6];
    logic [W-1:0] d_exp;
    RESET = 1'b1; fifo_wr = 0; fifo_wr_ch = 0; fifo_wdata = 0; fifo_rd = 0; fifo_rd_ch = 0;
    fifo_flush = 0; err_clr = 0;
    drive(0, 0, '0, 0, 0, '0, 0, 1);
    drive(0, 0, '0, 0, 0, '0, 0, 1);
    idle();
    chk("rst_empty", fifo_empty, 4'b1111);
    chk("rst_full", fifo_full, 4'b0000);
    chk("rst_level", fifo_level, 16'h0000);
    chk("rst_rvalid", fifo_rvalid, 1'b0);
    chk("rst_wr_l", sif.wr_l, 1'b1);
    chk("rst_rd_l", sif.rd_l, 1'b1);

    // fill ch2, overflow, drain in order
    for (int i = 0; i < 8; i++) drive(1, 2, 64'(i), 0, 0);
    drive(1, 2, 64'd8, 0, 0);
    chk("ch2_full", fifo_full, 4'b0100);
    chk("ch2_level8", fifo_level[11:8], 4'd8);
    chk("ovf_wr_l", sif.wr_l, 1'b1);
    idle();
    chk("ovf_err2", ovf_err, 4'b0100);
    chk("ch2_level_keep", fifo_level[11:8], 4'd8);
    for (int j = 0; j < 10; j++) begin
      drive(0, 0, '0, j < 8, 2);
      if (j >= 2) begin
        chk("drain_rvalid", fifo_rvalid, 1'b1);
        chk("drain_rch", fifo_rch, 2'd2);
        chk("drain_data", fifo_rdata, 64'(j - 2));
      end
    end
    chk("ch2_empty", fifo_empty[2], 1'b1);

    // back-to-back reads across channels
    drive(1, 0, 64'hA0, 0, 0);
    drive(1, 0, 64'hA1, 0, 0);
    drive(1, 1, 64'hB0, 0, 0);
    idle();
    rseq[0] = 2'd0; rseq[1] = 2'd1; rseq[2] = 2'd0;
    rch_exp[2] = 2'd0; rch_exp[3] = 2'd1; rch_exp[4] = 2'd0;
    exp_v = 6'b011100;
    for (int j = 0; j < 6; j++) begin
      drive(0, 0, '0, j < 3, (j < 3) ? int'(rseq[j]) : 0);
      chk("b2b_rvalid", fifo_rvalid, exp_v[j]);
      if (exp_v[j]) chk("b2b_rch", fifo_rch, rch_exp[j]);
    end

    // ch1 at level 4, simultaneous write+read with pointer wrap
    for (int i = 0; i < 4; i++) drive(1, 1, 64'h100 + 64'(i), 0, 0);
    for (int j = 0; j < 12; j++) begin
      drive(j < 10, 1, 64'h200 + 64'(j), j < 10, 1);
      if (j >= 2) begin
        d_exp = (j - 2 < 4) ? 64'h100 + 64'(j - 2) : 64'h200 + 64'(j - 6);
        chk("wr_rd_data", fifo_rdata, d_exp);
      end
    end
    chk("ch1_level4", fifo_level[7:4], 4'd4);

    // flush ch3 against a same-cycle write
    for (int i = 0; i < 5; i++) drive(1, 3, 64'h300 + 64'(i), 0, 0);
    drive(1, 3, 64'hDEAD, 0, 0, 4'b1000);
    chk("flush_wr_l", sif.wr_l, 1'b1);
    idle();
    chk("flush_level3", fifo_level[15:12], 4'd0);
    chk("flush_empty3", fifo_empty[3], 1'b1);
    chk("flush_no_ovf", ovf_err, 4'b0100);

    // underflow, clear, set-wins-over-clear
    drive(0, 0, '0, 1, 0);
    chk("udf_rd_l", sif.rd_l, 1'b1);
    idle();
    chk("udf_err0", udf_err, 4'b0001);
    drive(0, 0, '0, 0, 0, '0, 1);
    idle();
    chk("clr_ovf", ovf_err, 4'b0000);
    chk("clr_udf", udf_err, 4'b0000);
    drive(0, 0, '0, 1, 0, '0, 1);
    idle();
    chk("set_wins", udf_err, 4'b0001);
    drive(0, 0, '0, 0, 0, '0, 1);

    // reset while a read is in flight
    drive(1, 0, 64'h777, 0, 0);
    idle();
    drive(0, 0, '0, 1, 0);
    drive(0, 0, '0, 0, 0, '0, 0, 1);
    for (int j = 0; j < 3; j++) begin
      idle();
      chk("rst_flight_rvalid", fifo_rvalid, 1'b0);
    end

    // mixed traffic checked by the model
    for (int j = 0; j < 300; j++)
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 3), {$urandom, $urandom},
            $urandom_range(0, 9) < 4, $urandom_range(0, 3),
            ($urandom_range(0, 15) == 0) ? NCH'(1 << $urandom_range(0, 3)) : '0,
            $urandom_range(0, 19) == 0);
    for (int j = 0; j < 4; j++) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
